// File: rtl/inst_fetch_queue.sv
// Instruction-fetch front end: sequential PC generation, credit-limited fetch requests,
// and a small response queue feeding ID, with stale-response discard on redirect.
module inst_fetch_queue #(
    parameter logic [31:0] RESET_PC        = 32'hBFC0_0000,
    parameter int          QDEPTH          = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] fetch_pc,
    output logic        fetch_req_valid,
    input  logic        fetch_req_ack,
    input  logic [31:0] resp_inst,
    input  logic [31:0] resp_pc,
    input  logic        resp_valid,
    output logic        resp_ack,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    input  logic        id_ready
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]   pc_q, pc_d;
    logic [OW-1:0] outst_q, outst_d, discard_q, discard_d, outst_after_rsp;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [31:0]   qpc_mem   [QDEPTH];
    logic [31:0]   qinst_mem [QDEPTH];

    logic          accept, push, pop, drop;
    logic [31:0]   credit_used;

    // Every accepted request reserves a queue slot, so pushes never meet a full queue.
    assign credit_used     = 32'(count_q) + 32'(outst_q);
    assign fetch_req_valid = ~rst & ~redirect_valid
                           & (32'(outst_q) < 32'(MAX_OUTSTANDING))
                           & (credit_used < 32'(QDEPTH));
    assign resp_ack        = ~rst;
    assign fetch_pc        = pc_q;

    assign accept   = fetch_req_valid & fetch_req_ack;
    assign drop     = resp_valid & (discard_q != '0);
    assign id_valid = (count_q != '0);
    assign id_inst  = id_valid ? qinst_mem[rd_q] : 32'h0;
    assign id_pc    = id_valid ? qpc_mem[rd_q]   : 32'h0;

    always_comb begin
        outst_after_rsp = outst_q;
        if (resp_valid && (outst_q != '0)) begin
            outst_after_rsp = outst_q - OW'(1);
        end
    end

    always_comb begin
        pc_d      = pc_q;
        outst_d   = outst_after_rsp;
        discard_d = discard_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        count_d   = count_q;
        push      = 1'b0;
        pop       = 1'b0;
        if (accept) begin
            outst_d = outst_after_rsp + OW'(1);
        end
        if (redirect_valid) begin
            // Everything still in flight belongs to the abandoned path.
            pc_d      = redirect_pc & 32'hFFFF_FFFC;
            discard_d = outst_after_rsp;
            rd_d      = '0;
            wr_d      = '0;
            count_d   = '0;
        end else begin
            if (accept) begin
                pc_d = pc_q + 32'd4;
            end
            if (drop) begin
                discard_d = discard_q - OW'(1);
            end
            push = resp_valid & ~drop;
            pop  = id_valid & id_ready;
            if (push) begin
                wr_d = wr_q + PW'(1);
            end
            if (pop) begin
                rd_d = rd_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            outst_q   <= '0;
            discard_q <= '0;
            count_q   <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
        end else begin
            pc_q      <= pc_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
            count_q   <= count_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
        end
    end

    // Queue storage carries data only; validity comes from count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            qpc_mem[wr_q]   <= resp_pc;
            qinst_mem[wr_q] <= resp_inst;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with an in-order, one-cycle-latency wrapper model.
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        fetch_req_valid;
    logic        fetch_req_ack;
    logic [31:0] resp_inst;
    logic [31:0] resp_pc;
    logic        resp_valid;
    logic        resp_ack;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_ready;

    int          errors = 0;
    int          checks = 0;
    int          pop_cnt = 0;
    int          a0, p0;
    logic        hold = 1'b0;
    logic [31:0] exp_next = 32'hBFC0_0000;
    logic [31:0] inflight[$];
    logic [31:0] acc_log[$];

    inst_fetch_queue dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_pc        (fetch_pc),
        .fetch_req_valid (fetch_req_valid),
        .fetch_req_ack   (fetch_req_ack),
        .resp_inst       (resp_inst),
        .resp_pc         (resp_pc),
        .resp_valid      (resp_valid),
        .resp_ack        (resp_ack),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .id_valid        (id_valid),
        .id_inst         (id_inst),
        .id_pc           (id_pc),
        .id_ready        (id_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] log_at(input int idx);
        if (idx < acc_log.size()) return acc_log[idx];
        return 32'hDEAD_BEEF;
    endfunction

    // One clock: sample handshakes mid-cycle, then drive the wrapper response after the edge.
    task automatic tick();
        @(negedge clk);
        if (fetch_req_valid && fetch_req_ack) begin
            inflight.push_back(fetch_pc);
            acc_log.push_back(fetch_pc);
        end
        if (id_valid && id_ready) begin
            chk("pop_pc", id_pc, exp_next);
            chk("pop_inst", id_inst, inst_of(exp_next));
            exp_next = exp_next + 32'd4;
            pop_cnt++;
        end
        if (redirect_valid) exp_next = redirect_pc & 32'hFFFF_FFFC;
        @(posedge clk);
        #1;
        if (rst) begin
            inflight.delete();
            resp_valid = 1'b0;
        end else if (!hold && inflight.size() > 0) begin
            resp_valid = 1'b1;
            resp_pc    = inflight.pop_front();
            resp_inst  = inst_of(resp_pc);
        end else begin
            resp_valid = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; fetch_req_ack = 1'b0; resp_inst = '0; resp_pc = '0; resp_valid = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        #12;
        chk("rst_req_valid", 32'(fetch_req_valid), 0);
        chk("rst_resp_ack", 32'(resp_ack), 0);
        chk("rst_id_valid", 32'(id_valid), 0);
        chk("rst_fetch_pc", fetch_pc, 32'hBFC0_0000);
        chk("rst_id_inst", id_inst, 0);
        chk("rst_id_pc", id_pc, 0);

        // Stream from reset
        @(posedge clk); #1;
        rst = 1'b0; fetch_req_ack = 1'b1; id_ready = 1'b1;
        #1;
        chk("first_req", 32'(fetch_req_valid), 1);
        chk("first_pc", fetch_pc, 32'hBFC0_0000);
        repeat (12) tick();
        chk("stream_pops", 32'(pop_cnt), 10);

        // Backpressure fills the queue
        id_ready = 1'b0;
        repeat (20) tick();
        chk("bp_id_valid", 32'(id_valid), 1);
        chk("bp_req_valid", 32'(fetch_req_valid), 0);
        chk("bp_inflight", 32'(inflight.size()), 0);
        chk("bp_head", id_pc, exp_next);
        id_ready = 1'b1;
        p0 = pop_cnt; a0 = acc_log.size();
        repeat (4) tick();
        chk("bp_pops", 32'(pop_cnt - p0), 4);
        chk("bp_resume", 32'(acc_log.size() > a0), 1);

        // Redirect with two requests in flight
        hold = 1'b1;
        repeat (3) tick();
        chk("rd1_outst", 32'(inflight.size()), 2);
        redirect_valid = 1'b1; redirect_pc = 32'h8000_1003;
        #1;
        chk("rd1_req_blocked", 32'(fetch_req_valid), 0);
        a0 = acc_log.size(); p0 = pop_cnt;
        tick();
        redirect_valid = 1'b0; hold = 1'b0;
        chk("rd1_id_empty", 32'(id_valid), 0);
        chk("rd1_fetch_pc", fetch_pc, 32'h8000_1000);
        repeat (8) tick();
        chk("rd1_target_req", log_at(a0), 32'h8000_1000);
        chk("rd1_pops", 32'(pop_cnt > p0), 1);

        // Redirect coinciding with a response and a pop; one request remains stale
        id_ready = 1'b0; hold = 1'b1;
        repeat (3) tick();
        chk("rd2_outst", 32'(inflight.size()), 2);
        hold = 1'b0;
        tick();
        id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0040_0012;
        chk("rd2_resp_present", 32'(resp_valid), 1);
        chk("rd2_id_present", 32'(id_valid), 1);
        a0 = acc_log.size(); p0 = pop_cnt;
        tick();
        redirect_valid = 1'b0;
        repeat (8) tick();
        chk("rd2_target_req", log_at(a0), 32'h0040_0010);
        chk("rd2_pops", 32'(pop_cnt > p0 + 1), 1);

        // PC wrap
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        a0 = acc_log.size();
        tick();
        redirect_valid = 1'b0;
        repeat (6) tick();
        chk("wrap_first", log_at(a0), 32'hFFFF_FFFC);
        chk("wrap_second", log_at(a0 + 1), 32'h0000_0000);

        // Reset with a full queue
        id_ready = 1'b0;
        repeat (20) tick();
        chk("mrst_full", 32'(id_valid), 1);
        rst = 1'b1;
        #1;
        chk("mrst_id_valid", 32'(id_valid), 0);
        chk("mrst_fetch_pc", fetch_pc, 32'hBFC0_0000);
        chk("mrst_req_valid", 32'(fetch_req_valid), 0);
        chk("mrst_resp_ack", 32'(resp_ack), 0);
        repeat (2) tick();
        rst = 1'b0; id_ready = 1'b1; exp_next = 32'hBFC0_0000;
        a0 = acc_log.size(); p0 = pop_cnt;
        repeat (8) tick();
        chk("mrst_restart_req", log_at(a0), 32'hBFC0_0000);
        chk("mrst_pops", 32'(pop_cnt > p0), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
